// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: ALUOp encodings, control bundle, bubble constant
package pipeline_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // Control bundle produced by the main decoder, carried down the pipe as a unit
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between EX and ID
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_luh
);

  // Both rs and rt are compared regardless of instruction format; $zero never carries a hazard
  assign o_luh = i_ex_valid & i_ex_mem_read & (i_ex_rt != '0) & i_id_valid &
                 ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble insertion; HAZARD_DETECT_EN enables load-use detection
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_read_data1,
  input  logic [DATA_W-1:0]     id_read_data2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_alu_op,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_read_data1,
  output logic [DATA_W-1:0]     ex_read_data2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [5:0]            ex_funct,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic [1:0]            ex_alu_op
);

  ctrl_t                 r_ctrl;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc_plus4;
  logic [DATA_W-1:0]     r_read_data1;
  logic [DATA_W-1:0]     r_read_data2;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [5:0]            r_funct;

  ctrl_t w_id_ctrl;
  logic  w_luh;
  logic  w_load;
  logic  w_bubble;

  assign w_id_ctrl = {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
                      id_mem_write, id_alu_src, id_reg_write, id_alu_op};

`ifdef HAZARD_DETECT_EN
  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rt       (r_rt),
    .i_id_valid    (id_valid),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_luh         (w_luh)
  );
`else
  assign w_luh = 1'b0;
`endif

  // Flush overrides hold; otherwise hold freezes everything, and a load-use turns the capture into a bubble
  assign w_load   = flush | ~ex_hold;
  assign w_bubble = flush | w_luh;
  assign stall    = ~flush & (ex_hold | w_luh);

  // Stage register: datapath fields always follow ID on a load; controls are zeroed for bubbles and non-valid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_valid      <= 1'b0;
      r_pc_plus4   <= '0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
    end else if (w_load) begin
      r_pc_plus4   <= id_pc_plus4;
      r_read_data1 <= id_read_data1;
      r_read_data2 <= id_read_data2;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_rd         <= id_rd;
      r_funct      <= id_funct;
      if (w_bubble) begin
        r_ctrl  <= CTRL_BUBBLE;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= id_valid ? w_id_ctrl : CTRL_BUBBLE;
        r_valid <= id_valid;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_read_data1 = r_read_data1;
  assign ex_read_data2 = r_read_data2;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage (expectations follow HAZARD_DETECT_EN)
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
  logic        id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]  id_alu_op;
  logic        flush, ex_hold;
  logic        stall, ex_valid;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
  logic        ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;

  int total = 0;
  int bad   = 0;

  // {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  localparam logic [8:0] C_LW  = 9'b0_0_1_1_0_1_1_00;
  localparam logic [8:0] C_SW  = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] C_ADD = 9'b1_0_0_0_0_0_1_10;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .id_read_data1(id_read_data1),
    .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [8:0] c);
    id_valid      = v;
    id_pc_plus4   = pc;
    id_read_data1 = pc + 32'd1;
    id_read_data2 = pc + 32'd2;
    id_imm        = pc + 32'd3;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_funct = 6'h20;
    {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
     id_mem_write, id_alu_src, id_reg_write, id_alu_op} = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 9'd0);
    #10;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_regwr", 32'(ex_reg_write), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // first edge after reset release captures normally: lw $8, 4($9)
    drive(1'b1, 32'h100, 5'd9, 5'd8, 5'd0, C_LW);
    tick();
    check("lw_valid", 32'(ex_valid), 32'd1);
    check("lw_memrd", 32'(ex_mem_read), 32'd1);
    check("lw_rt", 32'(ex_rt), 32'd8);
    check("lw_pc", ex_pc_plus4, 32'h100);
    check("lw_imm", ex_imm, 32'h103);

    // add $11, $8, $10 right behind the load
    drive(1'b1, 32'h104, 5'd8, 5'd10, 5'd11, C_ADD);
`ifdef HAZARD_DETECT_EN
    check("luh_stall", 32'(stall), 32'd1);
    tick();
    check("luh_bub_valid", 32'(ex_valid), 32'd0);
    check("luh_bub_regwr", 32'(ex_reg_write), 32'd0);
    check("luh_stall_off", 32'(stall), 32'd0);
    tick();
`else
    check("noluh_stall", 32'(stall), 32'd0);
    tick();
`endif
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_rs", 32'(ex_rs), 32'd8);
    check("add_aluop", 32'(ex_alu_op), 32'd2);
    check("add_pc", ex_pc_plus4, 32'h104);

    // $zero exemption: lw $0 followed by add using $0
    drive(1'b1, 32'h108, 5'd9, 5'd0, 5'd0, C_LW);
    tick();
    drive(1'b1, 32'h10C, 5'd0, 5'd0, 5'd11, C_ADD);
    check("zero_stall", 32'(stall), 32'd0);
    tick();
    check("zero_valid", 32'(ex_valid), 32'd1);
    check("zero_pc", ex_pc_plus4, 32'h10C);
    check("zero_regdst", 32'(ex_reg_dst), 32'd1);

    // flush with hold and a pending load-use: sw $8 behind lw $8
    drive(1'b1, 32'h110, 5'd9, 5'd8, 5'd0, C_LW);
    tick();
    drive(1'b1, 32'h114, 5'd9, 5'd8, 5'd0, C_SW);
    flush = 1'b1; ex_hold = 1'b1; #1;
    check("flush_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0; ex_hold = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_memwr", 32'(ex_mem_write), 32'd0);

    // hold for three edges with an R-type in EX
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd11, C_ADD);
    tick();
    drive(1'b1, 32'h300, 5'd3, 5'd4, 5'd12, C_LW);
    ex_hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_stall", 32'(stall), 32'd1);
      tick();
      check("hold_pc", ex_pc_plus4, 32'h200);
      check("hold_aluop", 32'(ex_alu_op), 32'(pipeline_pkg::ALUOP_RTYPE));
      check("hold_rd", 32'(ex_rd), 32'd11);
    end
    ex_hold = 1'b0; #1;
    check("release_stall", 32'(stall), 32'd0);
    tick();
    check("release_pc", ex_pc_plus4, 32'h300);
    check("release_rd", 32'(ex_rd), 32'd12);
    check("release_memrd", 32'(ex_mem_read), 32'd1);

    // non-valid ID slot never carries controls
    drive(1'b0, 32'h400, 5'd5, 5'd6, 5'd7, C_SW | C_ADD);
    tick();
    check("inv_memwr", 32'(ex_mem_write), 32'd0);
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_regwr", 32'(ex_reg_write), 32'd0);
    check("inv_pc", ex_pc_plus4, 32'h400);

    // asynchronous reset mid-stream with reg_write set in EX
    drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd13, C_ADD);
    tick();
    check("pre_rst_regwr", 32'(ex_reg_write), 32'd1);
    rst_n = 1'b0; #1;
    check("arst_regwr", 32'(ex_reg_write), 32'd0);
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_pc", ex_pc_plus4, 32'h0);
    check("arst_stall", 32'(stall), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(ex_valid), 32'd1);
    check("post_rst_rd", 32'(ex_rd), 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage pipelined MIPS core. Registers the decoded control bundle (RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp), operands, immediate and register specifiers from Instruction Decode for the Execute stage. It owns load-use hazard detection and bubble insertion, and arbitrates flush and downstream hold.

## Interface
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register specifier width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4, id_read_data1, id_read_data2, id_imm  in  DATA_W each  PC+4, rs/rt read data, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  register specifiers
- id_funct  in  6  instruction funct field
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control unit outputs
- id_alu_op  in  2  control unit ALUOp
- flush  in  1  taken branch/jump; kill the instruction entering EX
- ex_hold  in  1  downstream (MEM) multi-cycle stall; freeze this stage
- stall  out  1  combinational; PC and IF/ID must hold
- ex_valid  out  1  EX slot holds a real instruction
- ex_* outputs  out  same widths  registered copies of every id_* input above

## Operation
- Every output register (ex_*, ex_valid) resets to 0. With all registers at 0, stall = 0.
- Load-use hazard: luh = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt). The comparison is conservative and always checks both rs and rt.
- Per-edge update priority:
  1. flush: load a bubble.
  2. else ex_hold: all registers keep their values.
  3. else luh: load a bubble.
  4. else capture all id_* inputs, and set ex_valid = id_valid.
- Bubble: ex_valid and all control outputs (the seven 1-bit controls and ex_alu_op) become 0. Datapath and specifier fields capture id_* normally; their values are don't-care.
- stall = ~flush & (ex_hold | luh).
- When id_valid = 0, the control fields are forced to 0 on capture. A non-valid instruction never produces MemRead, MemWrite, RegWrite or Branch in EX.

## Timing
- Latency is 1 cycle from id_* to ex_*.
- stall is combinational from registered state plus same-cycle id_*/flush/ex_hold. It is valid before the edge and has no registered delay.
- A load-use stall lasts exactly 1 cycle. The following cycle the EX slot holds a bubble, so luh = 0 and the dependent instruction is captured.
- ex_hold held for N cycles freezes contents for N edges. A luh present at release is evaluated then.
- flush and ex_hold in the same cycle: flush wins, the bubble loads, stall = 0.
- flush and luh in the same cycle: bubble, stall = 0.
- rst_n asserted mid-operation clears outputs immediately (asynchronous). Deassertion is sampled on the clk edge, and the first post-reset edge performs a normal capture.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection as specified above.
- Not defined: luh is tied 0, so stall = ~flush & ex_hold. Software or the compiler must schedule load delay slots.

## Structure
- The shared package pipeline_pkg holds:
  - ALUOp encodings: ALUOP_MEM = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_RTYPE = 2'b10.
  - A packed ctrl_t struct for the control bundle.
  - The CTRL_BUBBLE constant (all zero).
- One sub-module, load_use_detect, is natural: purely combinational, producing luh. It is instantiated only under HAZARD_DETECT_EN.

## Test plan
- Reset:
  - Stimulus: rst_n low mid-stream with ex_reg_write = 1.
  - Required: all ex_* and ex_valid go to 0 immediately; stall = 0.
- Load-use:
  - Stimulus: lw with rt=8 in EX, then add with rs=8 in ID.
  - Required: stall = 1 for one cycle; next edge ex_valid = 0, ex_reg_write = 0; following edge add is captured with ex_rs = 8.
- $zero exemption:
  - Stimulus: lw with rt=0 in EX, then add with rs=0 in ID.
  - Required: stall = 0 and add is captured on the next edge.
- Flush priority:
  - Stimulus: flush = 1 together with ex_hold = 1 and a pending luh.
  - Required: stall = 0; next edge ex_valid = 0 and ex_mem_write = 0.
- Hold:
  - Stimulus: ex_hold high for 3 cycles with an R-type (ex_alu_op = 2'b10) in EX.
  - Required: ex_* unchanged for 3 edges and stall = 1 throughout; new instruction captured on the 4th edge.
- Invalid capture:
  - Stimulus: id_valid = 0 with id_mem_write = 1.
  - Required: ex_mem_write = 0 and ex_valid = 0 after the edge.
